arbiter_n_to_1_request_scheduler: RTL and testbench

ARBITER_N_TO_1_REQUEST_SCHEDULER -- requirements
Module: arbiter_N_to_1_request_scheduler

---
 rtl/arbiter_n_to_1_request_scheduler_pkg.sv | 20 ++
 rtl/arbiter_n_to_1_request_scheduler_round_robin_priority_select.sv | 38 +++
 rtl/arbiter_n_to_1_request_scheduler.sv | 138 +++++++++++++
 tb/tb_arbiter_n_to_1_request_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_n_to_1_request_scheduler_pkg.sv
// rtl/arbiter_n_to_1_request_scheduler_pkg.sv - shared types for the N-to-1 request scheduler
// Contents: MemoryPacket (valid + payload), scheduler_state_t, default outstanding limit.
package arbiter_n_to_1_request_scheduler_pkg;

  localparam int PAYLOAD_WIDTH           = 32;
  localparam int MAX_OUTSTANDING_DEFAULT = 16;

  typedef struct packed {
    logic                     valid;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } MemoryPacket;

  typedef enum logic [1:0] {
    SETUP,
    IDLE,
    GRANT,
    THROTTLE
  } scheduler_state_t;

endpackage

// File: rtl/arbiter_n_to_1_request_scheduler_round_robin_priority_select.sv
// rtl/arbiter_n_to_1_request_scheduler_round_robin_priority_select.sv - round-robin one-hot picker
// Ports:
//   request_vec   in   N       candidate requests
//   pointer       in   PTR_W   highest-priority index this cycle
//   grant_onehot  out  N       one-hot winner (all zero when nothing requests)
//   grant_index   out  PTR_W   binary index of the winner
//   grant_valid   out  1       a winner exists
module round_robin_priority_select #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     request_vec,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant_onehot,
  output logic [PTR_W-1:0] grant_index,
  output logic             grant_valid
);

  // Scan from pointer upward, wrapping at N; the extra bit in cand keeps
  // pointer+offset from overflowing before the wrap is applied.
  always_comb begin
    logic [PTR_W:0] cand;
    cand         = '0;
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, pointer} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(N)) cand = cand - (PTR_W+1)'(N);
      if (!grant_valid && request_vec[cand[PTR_W-1:0]]) begin
        grant_valid                     = 1'b1;
        grant_index                     = cand[PTR_W-1:0];
        grant_onehot[cand[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_n_to_1_request_scheduler.sv
// rtl/arbiter_n_to_1_request_scheduler.sv - N-to-1 round-robin memory request scheduler
// Optional feature macro: ARBITER_OUTSTANDING_LIMIT_EN (outstanding-count limit and retire tracking).
// Ports:
//   ap_clk                 in   1        clock, rising edge
//   areset                 in   1        asynchronous active-high reset
//   request_in             in   N x MemoryPacket  per-requester packet
//   request_ready_out      out  N        one-hot grant (packet consumed when valid & ready)
//   downstream_ready_in    in   1        memory channel can accept
//   response_retire_in     in   1        one response returned
//   request_out            out  MemoryPacket  registered winning packet, valid one cycle after accept
//   outstanding_count_out  out  clog2(MAX)+1  in-flight request count
//   fifo_setup_signal      out  1        high during post-reset setup
module arbiter_n_to_1_request_scheduler
  import arbiter_n_to_1_request_scheduler_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int MAX_OUTSTANDING      = MAX_OUTSTANDING_DEFAULT,
  parameter int SETUP_CYCLES         = 8
) (
  input  logic                                 ap_clk,
  input  logic                                 areset,
  input  MemoryPacket [NUM_MEMORY_REQUESTOR-1:0] request_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0]      request_ready_out,
  input  logic                                 downstream_ready_in,
  input  logic                                 response_retire_in,
  output MemoryPacket                          request_out,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_count_out,
  output logic                                 fifo_setup_signal
);

  localparam int N       = NUM_MEMORY_REQUESTOR;
  localparam int PTR_W   = $clog2(N);
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SETUP_W = $clog2(SETUP_CYCLES + 1);

  scheduler_state_t         state;
  logic [PTR_W-1:0]         pointer;
  logic [SETUP_W-1:0]       setup_count;
  logic                     out_valid;
  logic [PAYLOAD_WIDTH-1:0] out_payload;

  logic [N-1:0]     valid_vec;
  logic             any_valid;
  logic             headroom;
  logic             limit_next;
  logic             grant_enable;
  logic [N-1:0]     grant_onehot;
  logic [PTR_W-1:0] grant_index;
  logic             accept;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < N; i++) valid_vec[i] = request_in[i].valid;
  end

  assign any_valid    = |valid_vec;
  assign grant_enable = (state == GRANT) && downstream_ready_in && headroom;

  round_robin_priority_select #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .request_vec  (valid_vec & {N{grant_enable}}),
    .pointer      (pointer),
    .grant_onehot (grant_onehot),
    .grant_index  (grant_index),
    .grant_valid  (accept)
  );

  // Ready is only raised toward a valid requester, so any grant is an accept.
  assign request_ready_out = grant_onehot;

`ifdef ARBITER_OUTSTANDING_LIMIT_EN
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             retire_eff;

  // A retire with nothing outstanding is spurious and must not wrap the count.
  assign retire_eff = response_retire_in && (count != '0);
  assign count_next = count + CNT_W'(accept) - CNT_W'(retire_eff);
  assign headroom   = count < CNT_W'(MAX_OUTSTANDING);
  assign limit_next = count_next >= CNT_W'(MAX_OUTSTANDING);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) count <= '0;
    else        count <= count_next;
  end

  assign outstanding_count_out = count;
`else
  logic unused_retire;
  assign unused_retire         = response_retire_in;
  assign headroom              = 1'b1;
  assign limit_next            = 1'b0;
  assign outstanding_count_out = '0;
`endif

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      state             <= SETUP;
      pointer           <= '0;
      setup_count       <= '0;
      fifo_setup_signal <= 1'b1;
      out_valid         <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) pointer <= (grant_index == PTR_W'(N-1)) ? '0 : grant_index + 1'b1;
      case (state)
        SETUP: begin
          setup_count <= setup_count + 1'b1;
          if (setup_count == SETUP_W'(SETUP_CYCLES-1)) begin
            state             <= IDLE;
            fifo_setup_signal <= 1'b0;
          end
        end
        IDLE: begin
          if (any_valid && downstream_ready_in && headroom) state <= GRANT;
        end
        GRANT: begin
          if (!downstream_ready_in || limit_next) state <= THROTTLE;
          else if (!any_valid)                     state <= IDLE;
        end
        THROTTLE: begin
          if (downstream_ready_in && headroom) state <= IDLE;
        end
        default: state <= SETUP;
      endcase
    end
  end

  // Payload needs no reset: it is only observed while out_valid is set.
  always_ff @(posedge ap_clk) begin
    if (accept) out_payload <= request_in[grant_index].payload;
  end

  assign request_out = {out_valid, out_payload};

endmodule

// File: tb/tb_arbiter_n_to_1_request_scheduler.sv
// tb/tb_arbiter_n_to_1_request_scheduler.sv - self-checking bench for the request scheduler
module tb_arbiter_n_to_1_request_scheduler;
  import arbiter_n_to_1_request_scheduler_pkg::*;

  localparam int N     = 4;
  localparam int MAXO  = 4;
  localparam int SETUP = 8;
`ifdef ARBITER_OUTSTANDING_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
  localparam int LIMIT  = MAXO;
`else
  localparam bit LIM_EN = 1'b0;
  localparam int LIMIT  = 1 << 30;
`endif

  logic                  ap_clk = 1'b0;
  logic                  areset;
  MemoryPacket [N-1:0]   req_in;
  logic [N-1:0]          request_ready_out;
  logic                  downstream_ready;
  logic                  response_retire;
  MemoryPacket           request_out;
  logic [2:0]            outstanding_count_out;
  logic                  fifo_setup_signal;

  arbiter_n_to_1_request_scheduler #(
    .NUM_MEMORY_REQUESTOR (N),
    .MAX_OUTSTANDING      (MAXO),
    .SETUP_CYCLES         (SETUP)
  ) dut (
    .ap_clk                (ap_clk),
    .areset                (areset),
    .request_in            (req_in),
    .request_ready_out     (request_ready_out),
    .downstream_ready_in   (downstream_ready),
    .response_retire_in    (response_retire),
    .request_out           (request_out),
    .outstanding_count_out (outstanding_count_out),
    .fifo_setup_signal     (fifo_setup_signal)
  );

  always #5 ap_clk = ~ap_clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: rules expressed in terms of the scheduler's modes,
  // a round-robin pointer, an integer in-flight count and the last accepted packet.
  typedef enum {M_SETUP, M_IDLE, M_GRANT, M_THROTTLE} mode_e;
  mode_e       m_mode;
  int          m_setup_left;
  int          m_ptr;
  int          m_count;
  bit          m_out_v;
  logic [31:0] m_out_p;

  always @(negedge ap_clk) begin : model_cmp
    int          win;
    int          nc;
    logic [N-1:0] v;
    logic [N-1:0] exp_ready;
    if (areset) begin
      m_mode = M_SETUP; m_setup_left = SETUP; m_ptr = 0; m_count = 0; m_out_v = 1'b0;
      check("m_rst_ready", request_ready_out, 0);
      check("m_rst_outv", request_out.valid, 0);
      check("m_rst_setup", fifo_setup_signal, 1);
      check("m_rst_count", outstanding_count_out, 0);
    end else begin
      win = -1;
      for (int p = 0; p < N; p++) v[p] = req_in[p].valid;
      if (m_mode == M_GRANT && downstream_ready && m_count < LIMIT)
        for (int k = 0; k < N; k++)
          if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      check("m_ready", request_ready_out, exp_ready);
      check("m_outv", request_out.valid, m_out_v);
      if (m_out_v) check("m_payload", request_out.payload, m_out_p);
      check("m_count", outstanding_count_out, m_count);
      check("m_setup", fifo_setup_signal, m_mode == M_SETUP);
      for (int p = 0; p < N; p++) if (request_ready_out[p]) grant_log.push_back(p);
      // advance to the state after the coming rising edge
      nc = m_count + (win >= 0 ? 1 : 0) - ((response_retire && m_count > 0) ? 1 : 0);
      if (!LIM_EN) nc = 0;
      m_out_v = (win >= 0);
      if (win >= 0) begin
        m_out_p = req_in[win].payload;
        m_ptr   = (win + 1) % N;
      end
      case (m_mode)
        M_SETUP: begin
          m_setup_left--;
          if (m_setup_left == 0) m_mode = M_IDLE;
        end
        M_IDLE:     if (|v && downstream_ready && m_count < LIMIT) m_mode = M_GRANT;
        M_GRANT: begin
          if (!downstream_ready || nc >= LIMIT) m_mode = M_THROTTLE;
          else if (!(|v))                       m_mode = M_IDLE;
        end
        M_THROTTLE: if (downstream_ready && m_count < LIMIT) m_mode = M_IDLE;
        default: ;
      endcase
      m_count = nc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk); #1;
      cyc++;
      for (int p = 0; p < N; p++) req_in[p].payload = {cyc[15:0], 16'(p)};
    end
  endtask

  task automatic set_valid(input logic [N-1:0] mask);
    for (int p = 0; p < N; p++) req_in[p].valid = mask[p];
  endtask

  function automatic int log_at(input int i);
    return (grant_log.size() > i) ? grant_log[i] : -1;
  endfunction

  int n_setup;

  initial begin
    areset = 1'b1; downstream_ready = 1'b1; response_retire = 1'b0;
    set_valid('0);
    for (int p = 0; p < N; p++) req_in[p].payload = '0;
    tick(3);
    check("rst_ready", request_ready_out, 0);
    check("rst_outv", request_out.valid, 0);
    check("rst_setup", fifo_setup_signal, 1);
    check("rst_count", outstanding_count_out, 0);

    areset = 1'b0;
    n_setup = 0;
    repeat (12) begin @(negedge ap_clk); if (fifo_setup_signal) n_setup++; end
    check("setup_len", n_setup, 8);
    tick(1);

    // two requesters alternate
    response_retire = 1'b1;
    grant_log.delete();
    set_valid(4'b0011);
    tick(8);
    set_valid('0);
    check("alt_g0", log_at(0), 0);
    check("alt_g1", log_at(1), 1);
    check("alt_g2", log_at(2), 0);
    check("alt_g3", log_at(3), 1);
    tick(2);

    // lone requester 2, then pointer sits at 3
    grant_log.delete();
    set_valid(4'b0100);
    tick(5);
    check("lone_n", grant_log.size(), 4);
    check("lone_g0", log_at(0), 2);
    check("lone_g3", log_at(3), 2);
    grant_log.delete();
    set_valid(4'b1100);
    tick(2);
    check("ptr3_g0", log_at(0), 3);
    check("ptr3_g1", log_at(1), 2);
    set_valid('0);
    tick(2);

    // reset in the middle of a grant stream
    set_valid(4'b1111);
    tick(3);
    areset = 1'b1;
    @(negedge ap_clk);
    check("midrst_ready", request_ready_out, 0);
    check("midrst_outv", request_out.valid, 0);
    check("midrst_setup", fifo_setup_signal, 1);
    check("midrst_count", outstanding_count_out, 0);
    tick(1);
    areset = 1'b0;
    grant_log.delete();
    n_setup = 0;
    repeat (12) begin @(negedge ap_clk); if (fifo_setup_signal) n_setup++; end
    check("setup_len2", n_setup, 8);
    tick(1);

    // downstream stall for 5 cycles, then resume round-robin
    downstream_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      check("stall_ready", request_ready_out, 0);
      if (i > 0) check("stall_outv", request_out.valid, 0);
      tick(1);
    end
    downstream_ready = 1'b1;
    tick(4);
    check("stall_g0", log_at(0), 0);
    check("stall_g2", log_at(2), 2);
    check("stall_resume", log_at(3), 3);
    set_valid('0);
    tick(2);

`ifdef ARBITER_OUTSTANDING_LIMIT_EN
    areset = 1'b1; tick(1); areset = 1'b0;
    response_retire = 1'b0;
    tick(9);
    grant_log.delete();
    set_valid(4'b0001);
    tick(12);
    check("lim_issued", grant_log.size(), 4);
    check("lim_count", outstanding_count_out, 4);
    response_retire = 1'b1; tick(1); response_retire = 1'b0;
    tick(6);
    check("lim_one_more", grant_log.size(), 5);
    check("lim_count2", outstanding_count_out, 4);
    set_valid('0);
    response_retire = 1'b1; tick(1); response_retire = 1'b0;
    tick(2);
    check("cnt_at3", outstanding_count_out, 3);
    set_valid(4'b0001);
    tick(1);
    response_retire = 1'b1;
    @(negedge ap_clk);
    check("acc_ret_ready", request_ready_out, 4'b0001);
    tick(1);
    response_retire = 1'b0;
    set_valid('0);
    check("acc_ret_count", outstanding_count_out, 3);
    tick(1);
    response_retire = 1'b1;
    tick(5);
    response_retire = 1'b0;
    check("retire_floor", outstanding_count_out, 0);
`else
    response_retire = 1'b0;
    grant_log.delete();
    set_valid(4'b0001);
    tick(12);
    check("nolim_issued", grant_log.size(), 11);
    check("nolim_count", outstanding_count_out, 0);
    set_valid('0);
    response_retire = 1'b1;
    tick(2);
    check("nolim_retire", outstanding_count_out, 0);
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
